// File: rtl/detector_sequencer_if.sv
// ----------------------------------------------------------------------------
// detector_sequencer_if
//
// Purpose:
//   Control/result bundle between the lab top level (switches/buttons side)
//   and the detector_sequencer.
//
// Modports:
//   master : the lab top level or bench; drives start/pattern and reads results.
//   slave  : the detector_sequencer; reads start/pattern and drives results.
//
// Signals:
//   start      request a run; accepted only while the sequencer is idle
//   pattern    LEN-bit pattern, captured on the accepting edge
//   busy       high while a run is in progress (CLEAR/SHIFT/DRAIN)
//   done       one-cycle pulse, results valid
//   hit_found  at least one aligned z=1 in the last run
//   hit_count  number of aligned z=1 samples (saturating)
//   first_hit  bit index of the first aligned z=1, 0 if none
//
// Optional feature (macro DETSEQ_ABORT_EN):
//   abort      master -> slave, cut the current run short
//   aborted    slave -> master, last run ended by abort
//
// Handshake: start is a request level sampled on each rising edge; it is
// taken only when the sequencer is idle (busy=0 and done=0), otherwise it is
// dropped, never queued. done marks the single cycle in which results are
// first valid; results then hold until the next accepted start.
// ----------------------------------------------------------------------------
interface detector_sequencer_if #(
    parameter int LEN   = 16,
    parameter int CNT_W = $clog2(LEN + 1)
);
    logic             start;
    logic [LEN-1:0]   pattern;
    logic             busy;
    logic             done;
    logic             hit_found;
    logic [CNT_W-1:0] hit_count;
    logic [CNT_W-1:0] first_hit;
`ifdef DETSEQ_ABORT_EN
    logic             abort;
    logic             aborted;

    modport master (
        output start, pattern, abort,
        input  busy, done, hit_found, hit_count, first_hit, aborted
    );

    modport slave (
        input  start, pattern, abort,
        output busy, done, hit_found, hit_count, first_hit, aborted
    );
`else
    modport master (
        output start, pattern,
        input  busy, done, hit_found, hit_count, first_hit
    );

    modport slave (
        input  start, pattern,
        output busy, done, hit_found, hit_count, first_hit
    );
`endif
endinterface

// File: rtl/detector_sequencer.sv
// ----------------------------------------------------------------------------
// detector_sequencer
//
// Purpose:
//   Drives a serial sequence-detector FSM (single input w, registered output z)
//   from a parallel test pattern and scores what comes back. On an accepted
//   start the pattern is copied into a shadow register, the detector is reset
//   for one cycle, then the pattern is shifted out LSB first, one bit per
//   clock. Each returned z is aligned to the w bit that produced it by a tag
//   pipe DET_LAT deep, and aligned hits are counted.
//
// Parameters:
//   LEN      pattern length in bits (>= 1)
//   DET_LAT  cycles from det_w presented to its det_z valid (>= 1)
//   CNT_W    width of hit_count / first_hit
//
// Ports:
//   clk        rising-edge clock
//   reset      asynchronous, active-high reset
//   ctl        detector_sequencer_if.slave (start/pattern in, results out)
//   det_z      detector output z
//   det_w      detector input w (registered)
//   det_reset  detector reset (registered)
//   state_dbg  current FSM state encoding, for observation only
//
// Optional feature (macro DETSEQ_ABORT_EN):
//   Adds ctl.abort / ctl.aborted. abort in CLEAR/SHIFT/DRAIN forces DONE on
//   the next edge, flushes the tag pipe without scoring and flags aborted.
//   Without the macro every run completes.
//
// Handshake: start is sampled every edge and taken only in IDLE; anything
// else is dropped. done pulses for one cycle in DONE; results hold from then
// until the next accepted start.
// ----------------------------------------------------------------------------
module detector_sequencer #(
    parameter int LEN     = 16,
    parameter int DET_LAT = 2,
    parameter int CNT_W   = $clog2(LEN + 1)
) (
    input  logic                 clk,
    input  logic                 reset,
    detector_sequencer_if.slave  ctl,
    input  logic                 det_z,
    output logic                 det_w,
    output logic                 det_reset,
    output logic [2:0]           state_dbg
);

    localparam int IDX_W = (LEN > 1) ? $clog2(LEN) : 1;
    localparam int DRN_W = (DET_LAT > 1) ? $clog2(DET_LAT) : 1;

    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(LEN - 1);
    localparam logic [DRN_W-1:0] LAST_DRN  = DRN_W'(DET_LAT - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CLEAR = 3'd1,
        S_SHIFT = 3'd2,
        S_DRAIN = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    // One entry per bit in flight through the detector.
    typedef struct packed {
        logic             valid;
        logic [IDX_W-1:0] idx;
    } tag_t;

    state_t               state_q, state_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic [DRN_W-1:0]     drain_q, drain_d;

    logic [LEN-1:0]       shadow_q;
    tag_t [DET_LAT-1:0]   tag_pipe_q;
    tag_t                 tag_in;
    tag_t                 tag_out;

    logic                 busy_q;
    logic                 done_q;
    logic                 hit_found_q;
    logic [CNT_W-1:0]     hit_count_q;
    logic [CNT_W-1:0]     first_hit_q;

    logic                 accept;
    logic                 abort_take;
    logic                 run_active;
    logic                 score;
    logic                 det_w_d;

    assign state_dbg     = state_q;
    assign ctl.busy      = busy_q;
    assign ctl.done      = done_q;
    assign ctl.hit_found = hit_found_q;
    assign ctl.hit_count = hit_count_q;
    assign ctl.first_hit = first_hit_q;

    assign tag_out = tag_pipe_q[DET_LAT-1];

    // ------------------------------------------------------------------
    // FSM state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            drain_q <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            drain_q <= drain_d;
        end
    end

    // ------------------------------------------------------------------
    // Next state, strobes and the next value of the registered outputs
    // ------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        drain_d    = drain_q;
        accept     = 1'b0;
        abort_take = 1'b0;
        run_active = (state_q == S_CLEAR) || (state_q == S_SHIFT) ||
                     (state_q == S_DRAIN);

        case (state_q)
            S_IDLE: begin
                if (ctl.start) begin
                    accept  = 1'b1;
                    state_d = S_CLEAR;
                end
            end
            S_CLEAR: begin
                state_d = S_SHIFT;
                idx_d   = '0;
            end
            S_SHIFT: begin
                if (idx_q == LAST_IDX) begin
                    state_d = S_DRAIN;
                    drain_d = '0;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            S_DRAIN: begin
                if (drain_q == LAST_DRN) begin
                    state_d = S_DONE;
                end else begin
                    drain_d = drain_q + 1'b1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

`ifdef DETSEQ_ABORT_EN
        if (ctl.abort && run_active) begin
            abort_take = 1'b1;
            state_d    = S_DONE;
        end
`endif

        // The bit shown on det_w in a SHIFT cycle is the one whose tag is
        // pushed in that same cycle, so it is derived from the next index.
        det_w_d = (state_d == S_SHIFT) ? shadow_q[idx_d] : 1'b0;

        tag_in.valid = (state_q == S_SHIFT);
        tag_in.idx   = (state_q == S_SHIFT) ? idx_q : '0;

        // A valid tag leaving the pipe lines up with the det_z it produced.
        // On abort, whatever is leaving is discarded along with the rest.
        score = tag_out.valid && det_z && !abort_take &&
                ((state_q == S_SHIFT) || (state_q == S_DRAIN));
    end

    // ------------------------------------------------------------------
    // Registered outputs, shadow pattern, tag pipe and scoring
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            det_reset   <= 1'b1;
            det_w       <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            shadow_q    <= '0;
            tag_pipe_q  <= '0;
            hit_found_q <= 1'b0;
            hit_count_q <= '0;
            first_hit_q <= '0;
        end else begin
            det_reset <= (state_d == S_CLEAR);
            det_w     <= det_w_d;
            busy_q    <= (state_d == S_CLEAR) || (state_d == S_SHIFT) ||
                         (state_d == S_DRAIN);
            done_q    <= (state_d == S_DONE);

            if (abort_take) begin
                tag_pipe_q <= '0;
            end else begin
                for (int i = DET_LAT - 1; i > 0; i--) begin
                    tag_pipe_q[i] <= tag_pipe_q[i-1];
                end
                tag_pipe_q[0] <= tag_in;
            end

            if (accept) begin
                shadow_q    <= ctl.pattern;
                hit_found_q <= 1'b0;
                hit_count_q <= '0;
                first_hit_q <= '0;
            end else if (score) begin
                if (hit_count_q != {CNT_W{1'b1}}) begin
                    hit_count_q <= hit_count_q + 1'b1;
                end
                if (!hit_found_q) begin
                    hit_found_q <= 1'b1;
                    first_hit_q <= CNT_W'(tag_out.idx);
                end
            end
        end
    end

`ifdef DETSEQ_ABORT_EN
    logic aborted_q;

    assign ctl.aborted = aborted_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            aborted_q <= 1'b0;
        end else if (accept) begin
            aborted_q <= 1'b0;
        end else if (abort_take) begin
            aborted_q <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_detector_sequencer.sv
// ----------------------------------------------------------------------------
// tb_detector_sequencer
//
// Bench for detector_sequencer with a stub detector whose z is w delayed two
// clocks and cleared by det_reset. Cycle k of a run is the cycle after the
// k-th rising edge following the accepting edge (edge 0); outputs are read on
// the falling edge inside that cycle. Define DETSEQ_ABORT_EN to build and
// exercise the abort feature.
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_detector_sequencer;

    localparam int LEN      = 16;
    localparam int DET_LAT  = 2;
    localparam int CNT_W    = $clog2(LEN + 1);
    localparam int DONE_CYC = LEN + DET_LAT + 2;

    // ------------------------------------------------------------------
    // Clock / reset
    // ------------------------------------------------------------------
    logic       clk   = 1'b0;
    logic       reset = 1'b1;
    logic       det_z;
    logic       det_w;
    logic       det_reset;
    logic [2:0] state_dbg;
    logic       z1 = 1'b0;
    logic       z2 = 1'b0;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    detector_sequencer_if #(.LEN(LEN), .CNT_W(CNT_W)) bus ();

    detector_sequencer #(
        .LEN     (LEN),
        .DET_LAT (DET_LAT),
        .CNT_W   (CNT_W)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .ctl       (bus),
        .det_z     (det_z),
        .det_w     (det_w),
        .det_reset (det_reset),
        .state_dbg (state_dbg)
    );

    // Stub detector: z = w two clocks later, cleared while det_reset is high.
    always @(posedge clk) begin
        if (det_reset) begin
            z1 <= 1'b0;
            z2 <= 1'b0;
        end else begin
            z1 <= det_w;
            z2 <= z1;
        end
    end
    assign det_z = z2;

    // ------------------------------------------------------------------
    // Checker
    // ------------------------------------------------------------------
    task automatic check_eq(input string tag, input logic [31:0] got,
                            input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // ------------------------------------------------------------------
    // Driver: one full run with cycle-by-cycle output checks.
    // repulse_cyc > 0 re-asserts start with pattern FFFF in that cycle.
    // ------------------------------------------------------------------
    task automatic run_check(input string name, input logic [LEN-1:0] pat,
                             input int repulse_cyc, input int exp_count,
                             input int exp_first, input int exp_found);
        logic [3:0] exp_v;
        logic [3:0] got_v;
        @(negedge clk);
        bus.start   = 1'b1;
        bus.pattern = pat;
        @(negedge clk);          // cycle 1
        bus.start = 1'b0;
        for (int k = 1; k <= DONE_CYC + 1; k++) begin
            if (k > 1) @(negedge clk);
            exp_v[3] = (k == 1);
            exp_v[2] = (k >= 2 && k <= LEN + 1) ? pat[k-2] : 1'b0;
            exp_v[1] = (k >= 1 && k < DONE_CYC);
            exp_v[0] = (k == DONE_CYC);
            got_v    = {det_reset, det_w, bus.busy, bus.done};
            check_eq($sformatf("%s cyc%0d {det_reset,det_w,busy,done}", name, k),
                     32'(got_v), 32'(exp_v));
            if (k == repulse_cyc) begin
                bus.start   = 1'b1;
                bus.pattern = '1;
            end else if (k == repulse_cyc + 1) begin
                bus.start = 1'b0;
            end
        end
        check_eq({name, " hit_count"}, 32'(bus.hit_count), 32'(exp_count));
        check_eq({name, " first_hit"}, 32'(bus.first_hit), 32'(exp_first));
        check_eq({name, " hit_found"}, 32'(bus.hit_found), 32'(exp_found));
        // Results must still be there a few idle cycles later.
        repeat (3) @(negedge clk);
        check_eq({name, " hit_count held"}, 32'(bus.hit_count), 32'(exp_count));
    endtask

    // Reset asserted in cycle 8 of an A5A5 run.
    task automatic reset_midrun();
        int done_seen;
        done_seen = 0;
        @(negedge clk);
        bus.start   = 1'b1;
        bus.pattern = 16'hA5A5;
        @(negedge clk);          // cycle 1
        bus.start = 1'b0;
        repeat (7) @(negedge clk);   // cycle 8
        // idx 0..3 (bits 1,0,1,0) have been scored by now.
        check_eq("midrun hit_count before reset", 32'(bus.hit_count), 32'd2);
        check_eq("midrun busy before reset", 32'(bus.busy), 32'd1);
        reset = 1'b1;
        #1;
        check_eq("midrun reset busy", 32'(bus.busy), 32'd0);
        check_eq("midrun reset det_reset", 32'(det_reset), 32'd1);
        check_eq("midrun reset hit_count", 32'(bus.hit_count), 32'd0);
        check_eq("midrun reset hit_found", 32'(bus.hit_found), 32'd0);
        check_eq("midrun reset det_w", 32'(det_w), 32'd0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        for (int k = 0; k < DONE_CYC + 4; k++) begin
            @(negedge clk);
            if (bus.done) done_seen++;
        end
        check_eq("midrun no done pulse after reset", 32'(done_seen), 32'd0);
        check_eq("midrun det_reset released in idle", 32'(det_reset), 32'd0);
    endtask

`ifdef DETSEQ_ABORT_EN
    // abort in cycle 6 of an FFFF run: idx 0 and 1 scored, idx 2 discarded.
    task automatic abort_run();
        @(negedge clk);
        bus.start   = 1'b1;
        bus.pattern = 16'hFFFF;
        @(negedge clk);          // cycle 1
        bus.start = 1'b0;
        repeat (5) @(negedge clk);   // cycle 6
        check_eq("abort done before abort", 32'(bus.done), 32'd0);
        bus.abort = 1'b1;
        @(negedge clk);          // cycle 7
        bus.abort = 1'b0;
        check_eq("abort done cyc7", 32'(bus.done), 32'd1);
        check_eq("abort busy cyc7", 32'(bus.busy), 32'd0);
        check_eq("abort aborted", 32'(bus.aborted), 32'd1);
        check_eq("abort hit_count", 32'(bus.hit_count), 32'd2);
        check_eq("abort first_hit", 32'(bus.first_hit), 32'd0);
        check_eq("abort hit_found", 32'(bus.hit_found), 32'd1);
        @(negedge clk);
        check_eq("abort done single pulse", 32'(bus.done), 32'd0);
        check_eq("abort aborted held", 32'(bus.aborted), 32'd1);
        // abort in IDLE is ignored
        bus.abort = 1'b1;
        @(negedge clk);
        bus.abort = 1'b0;
        check_eq("abort in idle busy", 32'(bus.busy), 32'd0);
        check_eq("abort in idle hit_count", 32'(bus.hit_count), 32'd2);
    endtask
`endif

    // ------------------------------------------------------------------
    // Main sequence
    // ------------------------------------------------------------------
    initial begin
        bus.start   = 1'b0;
        bus.pattern = '0;
`ifdef DETSEQ_ABORT_EN
        bus.abort   = 1'b0;
`endif
        repeat (2) @(negedge clk);
        check_eq("reset busy", 32'(bus.busy), 32'd0);
        check_eq("reset done", 32'(bus.done), 32'd0);
        check_eq("reset det_reset", 32'(det_reset), 32'd1);
        check_eq("reset det_w", 32'(det_w), 32'd0);
        check_eq("reset hit_found", 32'(bus.hit_found), 32'd0);
        check_eq("reset hit_count", 32'(bus.hit_count), 32'd0);
        check_eq("reset first_hit", 32'(bus.first_hit), 32'd0);
`ifdef DETSEQ_ABORT_EN
        check_eq("reset aborted", 32'(bus.aborted), 32'd0);
`endif
        reset = 1'b0;
        repeat (2) @(negedge clk);

        // start re-pulsed in cycle 5 with FFFF must not disturb the A5A5 run
        run_check("a5a5", 16'hA5A5, 5, 8, 0, 1);
        run_check("8000", 16'h8000, 0, 1, 15, 1);
        run_check("0000", 16'h0000, 0, 0, 0, 0);
        reset_midrun();
        run_check("0110 after reset", 16'h0110, 0, 2, 4, 1);
        run_check("ffff", 16'hFFFF, 0, 16, 0, 1);
`ifdef DETSEQ_ABORT_EN
        abort_run();
        run_check("a5a5 after abort", 16'hA5A5, 0, 8, 0, 1);
        check_eq("aborted cleared by next start", 32'(bus.aborted), 32'd0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    // Absolute guard so the run always ends.
    initial begin
        #200000;
        $display("FAIL timeout: simulation ran past time limit");
        $fatal(1);
    end

endmodule
